calc_op_scheduler: RTL and testbench
====================================

// Module: calc_op_scheduler
// PURPOSE
//  Sequences the calculator's arithmetic units (add, sub, mul, div) from the
//  four front-panel operation buttons. Synchronises and edge-detects the raw
//  buttons, picks one request, latches both 9-bit two's-complement operands,
//  starts the selected unit with a one-cycle pulse and waits for its done.
//  Registers the returned result for the display path, with a timeout guard.
// PARAMETERS
//  WIDTH    9   operand/result width, two's complement (8 bits + 1 guard bit)
//  TIMEOUT  31  max cycles in WAIT before a unit is declared hung (1..255)
// PORTS
//  relogio     in   1      system clock, all state on rising edge
//  repor_n     in   1      asynchronous active-low reset
//  but_n       in   4      raw buttons, active-low: [0]=add [1]=sub [2]=mul [3]=div
//  num1        in   WIDTH  first operand from entry logic
//  num2        in   WIDTH  second operand from entry logic
//  opnd1       out  WIDTH  latched first operand, shared by all units
//  opnd2       out  WIDTH  latched second operand, shared by all units
//  start       out  4      one-hot start pulse, same bit order as but_n
//  done        in   4      one-cycle done pulse from each unit
//  res_add     in   WIDTH  adder result
//  res_sub     in   WIDTH  subtractor result
//  res_mul     in   WIDTH  multiplier result
//  res_div     in   WIDTH  divider result
//  result      out  WIDTH  last completed result
//  result_ok   out  1      one-cycle pulse when result updates
//  op_code     out  2      operation of the op in flight / last op (0..3)
//  busy        out  1      high from LATCH through STORE
//  erro        out  1      sticky timeout flag
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, FSM=IDLE, sync flops=1.
//  - Each but_n bit goes through a 2-flop synchroniser; request = 1->0 edge of
//    the synchronised bit (a press is seen 3 cycles after the raw fall).
//  - Held buttons give one request only; a new request needs release + press.
//  - FSM: IDLE -> LATCH -> START -> WAIT -> STORE -> IDLE.
//    IDLE: on any request, pick lowest index (add>sub>mul>div), set op_code,
//      go LATCH. Simultaneous requests: only the winner is served; losers lost.
//    LATCH: opnd1<=num1, opnd2<=num2; busy=1. Operands stay constant until the
//      next LATCH.
//    START: start[op_code]=1 for exactly this cycle; timeout counter cleared.
//    WAIT: on done[op_code] -> STORE. done of any other unit is ignored.
//      Counter +1 per cycle; on reaching TIMEOUT with no done: erro<=1,
//      result unchanged, -> IDLE.
//    STORE: result<=res_<op>, result_ok=1 for this cycle, -> IDLE.
//  - done arriving in the same cycle the counter hits TIMEOUT: done wins.
//  - Requests seen while busy=1 are dropped, not queued.
//  - erro clears when the next request is accepted (IDLE->LATCH).
//  - Minimum latency request-edge -> result_ok: 4 cycles + unit latency.
//  - Reset mid-operation: abort at once, no start/result_ok; a late done after
//    reset release is ignored (FSM in IDLE).
//  - Result is passed through unmodified; width/overflow belong to the units.
// TESTING
//  1 Reset: repor_n=0 mid-WAIT -> all outputs 0 in the same cycle, state IDLE.
//  2 Sub: num1=9'd20, num2=9'd7, press but_n[1], unit done 10 cycles after
//    start -> start=4'b0010 one cycle, result=9'd13, result_ok one pulse, op_code=1.
//  3 Priority: but_n[0] and but_n[3] fall same cycle -> only start[0] pulses;
//    div never started.
//  4 Busy drop: press sub, press add during WAIT -> add ignored, one result_ok.
//  5 Timeout: press mul, no done -> erro=1 after TIMEOUT WAIT cycles, no
//    result_ok, result unchanged; next add press clears erro, completes normally.
//  6 Negative: num1=9'd3, num2=9'd5 sub -> result=9'h1FE (-2); held button 50
//    cycles -> exactly one start pulse.

Source files
------------

// File: rtl/calc_op_scheduler.sv
// calc_op_scheduler
// Turns the four front-panel operation buttons into one operation on the
// shared arithmetic units. Button presses pass through synchronisers and
// fall-edge detectors. One request is picked, and both operands are latched.
// The chosen unit gets a one-cycle start pulse. The scheduler then waits for
// that unit's done, with a timeout so a hung unit cannot lock the panel.
module calc_op_scheduler #(
  parameter int WIDTH   = 9,
  parameter int TIMEOUT = 31
) (
  input  logic             relogio,
  input  logic             repor_n,
  input  logic [3:0]       but_n,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] opnd1,
  output logic [WIDTH-1:0] opnd2,
  output logic [3:0]       start,
  input  logic [3:0]       done,
  input  logic [WIDTH-1:0] res_add,
  input  logic [WIDTH-1:0] res_sub,
  input  logic [WIDTH-1:0] res_mul,
  input  logic [WIDTH-1:0] res_div,
  output logic [WIDTH-1:0] result,
  output logic             result_ok,
  output logic [1:0]       op_code,
  output logic             busy,
  output logic             erro
);

  // The WAIT counter only has to reach TIMEOUT-1. Reaching that value with
  // no done means the unit has been given TIMEOUT full cycles.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_STORE
  } state_t;

  state_t          state, state_n;
  logic [3:0]      sync1, sync2, sync_prev;
  logic [3:0]      req;
  logic            any_req;
  logic [1:0]      req_idx;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;
  logic            done_sel;
  logic [WIDTH-1:0] res_sel;

  // Synchronise the raw buttons. Keep one extra stage so a falling edge
  // can be detected. The flops reset to 1, which means "released".
  // NOTE: clocked state is written only with <= so that every flop samples
  // the values from before the edge; using = here would collapse the chain.
  always_ff @(posedge relogio or negedge repor_n) begin
    if (!repor_n) begin
      sync1     <= '1;
      sync2     <= '1;
      sync_prev <= '1;
    end else begin
      sync1     <= but_n;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // A request is a 1->0 edge of the synchronised button, so a held button
  // gives only one request.
  assign req     = sync_prev & ~sync2;
  assign any_req = |req;

  // Fixed priority: add > sub > mul > div. Requests that lose are dropped.
  // NOTE: every combinational output gets a default before the decision
  // logic. A path that leaves one unassigned would infer a latch.
  always_comb begin
    req_idx = 2'd0;
    if      (req[0]) req_idx = 2'd0;
    else if (req[1]) req_idx = 2'd1;
    else if (req[2]) req_idx = 2'd2;
    else if (req[3]) req_idx = 2'd3;
  end

  // Select the result and done of the unit that is in flight.
  always_comb begin
    res_sel = res_add;
    unique case (op_code)
      2'd0: res_sel = res_add;
      2'd1: res_sel = res_sub;
      2'd2: res_sel = res_mul;
      2'd3: res_sel = res_div;
      default: res_sel = res_add;
    endcase
  end

  assign done_sel    = done[op_code];
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge relogio or negedge repor_n) begin
    if (!repor_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state logic and the pulse-style outputs decoded from the state.
  // These outputs are decoded from the state, so an async reset forces
  // them to 0 at once.
  always_comb begin
    state_n   = state;
    start     = 4'b0000;
    result_ok = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:  if (any_req) state_n = ST_LATCH;
      ST_LATCH: state_n = ST_START;
      ST_START: begin
        start   = 4'b0001 << op_code;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a timeout in the same cycle.
        if (done_sel)         state_n = ST_STORE;
        else if (timeout_hit) state_n = ST_IDLE;
      end
      ST_STORE: begin
        result_ok = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Operation select and the sticky timeout flag. erro clears only when a
  // new request is accepted.
  always_ff @(posedge relogio or negedge repor_n) begin
    if (!repor_n) begin
      op_code <= 2'd0;
      erro    <= 1'b0;
    end else if (state == ST_IDLE && any_req) begin
      op_code <= req_idx;
      erro    <= 1'b0;
    end else if (state == ST_WAIT && !done_sel && timeout_hit) begin
      erro    <= 1'b1;
    end
  end

  // Operand latch. The operands stay constant until the next LATCH.
  always_ff @(posedge relogio or negedge repor_n) begin
    if (!repor_n) begin
      opnd1 <= '0;
      opnd2 <= '0;
    end else if (state == ST_LATCH) begin
      opnd1 <= num1;
      opnd2 <= num2;
    end
  end

  // Count WAIT cycles. The counter clears in START and advances on each
  // WAIT cycle that has no done.
  always_ff @(posedge relogio or negedge repor_n) begin
    if (!repor_n) begin
      cnt <= '0;
    end else if (state == ST_START) begin
      cnt <= '0;
    end else if (state == ST_WAIT && !done_sel && !timeout_hit) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the unit's result in the cycle its done is accepted. The new
  // value is then visible in STORE, while result_ok is high.
  always_ff @(posedge relogio or negedge repor_n) begin
    if (!repor_n) begin
      result <= '0;
    end else if (state == ST_WAIT && done_sel) begin
      result <= res_sel;
    end
  end

endmodule

// File: tb/tb_calc_op_scheduler.sv
// tb_calc_op_scheduler
// Randomised and directed operations checked against a transaction-level
// model. The bench plays the four arithmetic units. It drives done and
// results from its own copy of the operands.
module tb_calc_op_scheduler;

  localparam int W  = 9;
  localparam int TO = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   but_n = 4'hF;
  logic [W-1:0] num1 = '0, num2 = '0;
  logic [W-1:0] opnd1, opnd2, result;
  logic [W-1:0] res_add, res_sub, res_mul, res_div;
  logic [3:0]   start;
  logic [3:0]   done = 4'h0;
  logic         result_ok, busy, erro;
  logic [1:0]   op_code;

  // Unit model state.
  logic [W-1:0] u_n1 = '0, u_n2 = '0, garb = '0;
  logic         res_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected architectural state.
  logic [W-1:0] exp_result = '0;

  always #5 clk = ~clk;

  calc_op_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .relogio(clk), .repor_n(rst_n), .but_n(but_n),
    .num1(num1), .num2(num2), .opnd1(opnd1), .opnd2(opnd2),
    .start(start), .done(done),
    .res_add(res_add), .res_sub(res_sub), .res_mul(res_mul), .res_div(res_div),
    .result(result), .result_ok(result_ok), .op_code(op_code),
    .busy(busy), .erro(erro)
  );

  function automatic logic [W-1:0] unit_res(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      0: return a + b;
      1: return a - b;
      2: begin p = a * b; return p[W-1:0]; end
      default: return (b == '0) ? '1 : a / b;
    endcase
  endfunction

  // Results are valid only around the done cycle; garbage otherwise.
  assign res_add = res_valid ? unit_res(0, u_n1, u_n2) : garb;
  assign res_sub = res_valid ? unit_res(1, u_n1, u_n2) : ~garb;
  assign res_mul = res_valid ? unit_res(2, u_n1, u_n2) : garb ^ 9'h0A5;
  assign res_div = res_valid ? unit_res(3, u_n1, u_n2) : garb ^ 9'h15A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One button press and the operation it causes. All actions happen at a
  // negedge: sample the outputs first, then drive the inputs. The press is
  // driven in cycle 0, LATCH falls in cycle 3 and START in cycle 4. The unit
  // pulses done in cycle 4+lat. lat > TO means the unit hangs; its done then
  // comes late, in cycle 4+TO+2, and must be ignored.
  task automatic run_op(input logic [3:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int hold, input bit noise, input bit busy_press);
    int exp_op, starts, oks, done_c, last;
    bit ok_run;
    logic [W-1:0] prev_res, want;
    exp_op = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) exp_op = i;
    ok_run   = (lat <= TO);
    done_c   = ok_run ? 4 + lat : 4 + TO + 2;
    prev_res = exp_result;
    want     = ok_run ? unit_res(exp_op, a, b) : prev_res;
    last     = done_c + 6;
    if (last < hold + 5) last = hold + 5;
    if (busy_press && last < 14) last = 14;
    starts = 0; oks = 0;
    num1 = a; num2 = b; u_n1 = a; u_n2 = b; garb = W'($urandom);
    but_n = but_n & ~mask;
    for (int c = 1; c <= last; c++) begin
      tick();
      // Sample.
      if (start != 4'h0) starts++;
      if (result_ok) oks++;
      if (c == 3) begin
        check("busy_latch", busy, 1'b1);
        check("op_code", op_code, exp_op);
      end
      if (c == 4) begin
        check("start_onehot", start, 4'b0001 << exp_op);
        check("erro_cleared", erro, 1'b0);
        check("opnd1", opnd1, a);
        check("opnd2", opnd2, b);
        check("result_held", result, prev_res);
      end
      if (ok_run) begin
        if (c == done_c + 1) begin
          check("result_ok", result_ok, 1'b1);
          check("result", result, want);
        end
        if (c == done_c + 2) check("idle_after", busy, 1'b0);
      end else begin
        if (c == 4 + TO) begin
          check("erro_early", erro, 1'b0);
          check("busy_wait", busy, 1'b1);
        end
        if (c == 4 + TO + 1) begin
          check("erro_timeout", erro, 1'b1);
          check("busy_timeout", busy, 1'b0);
        end
      end
      // Drive.
      done = 4'h0;
      if (c == 4) begin num1 = W'($urandom); num2 = W'($urandom); end
      if (c == done_c) begin done[exp_op] = 1'b1; res_valid = 1'b1; end
      if (c == done_c + 2) res_valid = 1'b0;
      if (noise && c == 5) done = done | (~(4'b0001 << exp_op) & 4'hF);
      if (c == hold) but_n = but_n | mask;
      if (busy_press && c == 6) but_n[0] = 1'b0;
      if (busy_press && c == 9) but_n[0] = 1'b1;
    end
    but_n = 4'hF; done = 4'h0; res_valid = 1'b0;
    check("start_count", starts, 1);
    check("result_ok_count", oks, ok_run ? 1 : 0);
    check("result_final", result, want);
    check("opnd1_stable", opnd1, a);
    check("erro_final", erro, !ok_run);
    exp_result = want;
  endtask

  task automatic reset_mid_wait();
    int oks, starts;
    num1 = 9'd40; num2 = 9'd2; u_n1 = num1; u_n2 = num2;
    but_n = 4'b1011;
    for (int c = 1; c <= 7; c++) tick();
    check("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_opnd1", opnd1, 0);
    check("rst_opnd2", opnd2, 0);
    check("rst_start", start, 0);
    check("rst_result", result, 0);
    check("rst_result_ok", result_ok, 0);
    check("rst_op_code", op_code, 0);
    check("rst_busy", busy, 0);
    check("rst_erro", erro, 0);
    tick();
    rst_n = 1'b1;
    but_n = 4'hF;
    oks = 0; starts = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (result_ok) oks++;
      if (start != 4'h0) starts++;
      done = 4'h0;
      if (c == 2) begin done[2] = 1'b1; res_valid = 1'b1; end
      if (c == 4) res_valid = 1'b0;
    end
    done = 4'h0;
    check("late_done_ok", oks, 0);
    check("late_done_start", starts, 0);
    check("late_done_busy", busy, 0);
    check("late_done_result", result, 0);
    exp_result = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_start", start, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_start", start, 0);
    check("idle_result_ok", result_ok, 0);

    // Sub 20-7 = 13. The unit answers 10 cycles after start.
    run_op(4'b0010, 9'd20, 9'd7, 10, 3, 1'b0, 1'b0);
    check("sub_13", result, 9'd13);
    check("sub_op_code", op_code, 1);
    // Add and div fall together: only add is served.
    run_op(4'b1001, 9'd100, 9'd55, 3, 4, 1'b1, 1'b0);
    check("prio_add", result, 9'd155);
    // A press during WAIT is dropped.
    run_op(4'b0010, 9'd9, 9'd4, 12, 2, 1'b0, 1'b1);
    // Mul hangs, so erro rises. The next add clears it.
    run_op(4'b0100, 9'd6, 9'd7, TO + 5, 2, 1'b0, 1'b0);
    run_op(4'b0001, 9'd1, 9'd2, 5, 2, 1'b0, 1'b0);
    check("after_timeout_add", result, 9'd3);
    // 3-5 = -2. The button is held 50 cycles.
    run_op(4'b0010, 9'd3, 9'd5, 4, 50, 1'b0, 1'b0);
    check("neg_result", result, 9'h1FE);
    // done arriving on the last allowed WAIT cycle wins.
    run_op(4'b1000, 9'd200, 9'd9, TO, 2, 1'b0, 1'b0);
    run_op(4'b0100, 9'd17, 9'd3, 1, 1, 1'b0, 1'b0);
    reset_mid_wait();

    for (int k = 0; k < 30; k++) begin
      logic [3:0] m;
      int lat;
      m   = 4'($urandom_range(1, 15));
      lat = ($urandom_range(0, 5) == 0) ? TO + 3 : $urandom_range(1, TO);
      run_op(m, W'($urandom), W'($urandom), lat, $urandom_range(1, 8),
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something runs away.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
